pw_seq_lock: RTL and testbench

//   Parametrised successor to the single-character password FSM: multi-character sequence lock

---
 rtl/pw_seq_lock_if.sv | 24 ++
 rtl/pw_seq_lock.sv | 167 ++++++++++++++++
 tb/tb_pw_seq_lock.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pw_seq_lock_if.sv
// Character/enter input bundle and status outputs of the pw_seq_lock sequence lock.
// master = board/stimulus side, slave = the lock itself.
interface pw_seq_lock_if #(
  parameter int CHAR_W    = 7,
  parameter int PW_LEN    = 4,
  parameter int MAX_TRIES = 3
);
  logic [CHAR_W-1:0]                  char_in;
  logic                               enter;
  logic                               open;
  logic                               locked_out;
  logic [$clog2(MAX_TRIES+1)-1:0]     fail_cnt;
  logic [$clog2(PW_LEN+1)-1:0]        entry_idx;

  modport master (
    output char_in, enter,
    input  open, locked_out, fail_cnt, entry_idx
  );

  modport slave (
    input  char_in, enter,
    output open, locked_out, fail_cnt, entry_idx
  );
endinterface

// File: rtl/pw_seq_lock.sv
// Multi-character sequence lock with consecutive-failure counting.
// Define PW_SEQ_LOCK_LOCKOUT_EN to build the timed LOCKOUT state after MAX_TRIES failures.
module pw_seq_lock #(
  parameter int                        CHAR_W      = 7,
  parameter int                        PW_LEN      = 4,
  parameter logic [PW_LEN*CHAR_W-1:0]  PASSWORD    = 28'h0ABCDEF,
  parameter int                        MAX_TRIES   = 3,
  parameter int                        LOCKOUT_CYC = 1024
) (
  input  logic          clk,
  input  logic          reset,
  pw_seq_lock_if.slave  bus
);
  localparam int FAIL_W = $clog2(MAX_TRIES + 1);
  localparam int IDX_W  = $clog2(PW_LEN + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(PW_LEN - 1);
  localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_TRIES);

`ifdef PW_SEQ_LOCK_LOCKOUT_EN
  localparam int CNT_W = $clog2(LOCKOUT_CYC);
  typedef enum logic [1:0] {ST_ENTRY, ST_OPEN, ST_LOCKOUT} state_t;
`else
  typedef enum logic [1:0] {ST_ENTRY, ST_OPEN} state_t;
`endif

  logic [CHAR_W-1:0] char_s1_reg, char_s2_reg;
  logic              enter_s1_reg, enter_s2_reg, enter_prev_reg;
  logic              enter_evt;

  state_t            state_reg, state_next;
  logic              open_reg, open_next;
  logic [FAIL_W-1:0] fail_reg, fail_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic              mismatch_reg, mismatch_next;
`ifdef PW_SEQ_LOCK_LOCKOUT_EN
  logic              locked_reg, locked_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
`endif

  logic [CHAR_W-1:0] pw_chars [PW_LEN];
  logic [CHAR_W-1:0] exp_char;
  logic              char_eq;

  for (genvar gi = 0; gi < PW_LEN; gi++) begin : g_pw_chars
    assign pw_chars[gi] = PASSWORD[gi*CHAR_W +: CHAR_W];
  end

  // Explicit compare-mux keeps the index width independent of the array size.
  always_comb begin
    exp_char = '0;
    for (int k = 0; k < PW_LEN; k++) begin
      if (idx_reg == IDX_W'(k)) exp_char = pw_chars[k];
    end
  end

  assign char_eq   = (char_s2_reg == exp_char);
  assign enter_evt = enter_s2_reg & ~enter_prev_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      char_s1_reg    <= '0;
      char_s2_reg    <= '0;
      enter_s1_reg   <= 1'b0;
      enter_s2_reg   <= 1'b0;
      enter_prev_reg <= 1'b0;
    end else begin
      char_s1_reg    <= bus.char_in;
      char_s2_reg    <= char_s1_reg;
      enter_s1_reg   <= bus.enter;
      enter_s2_reg   <= enter_s1_reg;
      enter_prev_reg <= enter_s2_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_ENTRY;
      open_reg     <= 1'b0;
      fail_reg     <= '0;
      idx_reg      <= '0;
      mismatch_reg <= 1'b0;
`ifdef PW_SEQ_LOCK_LOCKOUT_EN
      locked_reg   <= 1'b0;
      cnt_reg      <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      open_reg     <= open_next;
      fail_reg     <= fail_next;
      idx_reg      <= idx_next;
      mismatch_reg <= mismatch_next;
`ifdef PW_SEQ_LOCK_LOCKOUT_EN
      locked_reg   <= locked_next;
      cnt_reg      <= cnt_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    open_next     = open_reg;
    fail_next     = fail_reg;
    idx_next      = idx_reg;
    mismatch_next = mismatch_reg;
`ifdef PW_SEQ_LOCK_LOCKOUT_EN
    locked_next   = locked_reg;
    cnt_next      = cnt_reg;
`endif
    case (state_reg)
      ST_ENTRY: begin
        if (enter_evt) begin
          // Wrong characters are still consumed so the failing position never leaks.
          if (idx_reg == LAST_IDX) begin
            idx_next      = '0;
            mismatch_next = 1'b0;
            if (!mismatch_reg && char_eq) begin
              state_next = ST_OPEN;
              open_next  = 1'b1;
              fail_next  = '0;
            end else begin
`ifdef PW_SEQ_LOCK_LOCKOUT_EN
              fail_next = fail_reg + 1'b1;
              if (fail_next == FAIL_MAX) begin
                state_next  = ST_LOCKOUT;
                locked_next = 1'b1;
                cnt_next    = CNT_W'(LOCKOUT_CYC - 1);
              end
`else
              if (fail_reg != FAIL_MAX) fail_next = fail_reg + 1'b1;
`endif
            end
          end else begin
            idx_next      = idx_reg + 1'b1;
            mismatch_next = mismatch_reg | ~char_eq;
          end
        end
      end
      ST_OPEN: begin
        if (enter_evt) begin
          state_next = ST_ENTRY;
          open_next  = 1'b0;
        end
      end
`ifdef PW_SEQ_LOCK_LOCKOUT_EN
      ST_LOCKOUT: begin
        if (cnt_reg == '0) begin
          state_next  = ST_ENTRY;
          locked_next = 1'b0;
          fail_next   = '0;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
`endif
      default: state_next = ST_ENTRY;
    endcase
  end

  assign bus.open      = open_reg;
  assign bus.fail_cnt  = fail_reg;
  assign bus.entry_idx = idx_reg;
`ifdef PW_SEQ_LOCK_LOCKOUT_EN
  assign bus.locked_out = locked_reg;
`else
  assign bus.locked_out = 1'b0;
`endif
endmodule

// File: tb/tb_pw_seq_lock.sv
// Randomised self-checking bench for pw_seq_lock against an attempt-level reference model.
// Lockout scenarios run only when PW_SEQ_LOCK_LOCKOUT_EN is defined; saturation otherwise.
module tb_pw_seq_lock;
  localparam int CHAR_W      = 7;
  localparam int PW_LEN      = 4;
  localparam int MAX_TRIES   = 3;
  localparam int LOCKOUT_CYC = 1024;
  localparam logic [PW_LEN*CHAR_W-1:0] PASSWORD = 28'h0ABCDEF;
  localparam int FAIL_W = $clog2(MAX_TRIES + 1);
  localparam int IDX_W  = $clog2(PW_LEN + 1);
`ifdef PW_SEQ_LOCK_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   lo_cycles = 0;

  pw_seq_lock_if #(.CHAR_W(CHAR_W), .PW_LEN(PW_LEN), .MAX_TRIES(MAX_TRIES)) bus ();

  pw_seq_lock #(
    .CHAR_W(CHAR_W), .PW_LEN(PW_LEN), .PASSWORD(PASSWORD),
    .MAX_TRIES(MAX_TRIES), .LOCKOUT_CYC(LOCKOUT_CYC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.locked_out === 1'b1) lo_cycles++;

  // Reference model: whole attempts are judged from the list of characters entered.
  bit                m_open;
  bit                m_locked;
  int                m_fail;
  logic [CHAR_W-1:0] m_q[$];

  function automatic logic [CHAR_W-1:0] pw_char(input int k);
    logic [PW_LEN*CHAR_W-1:0] p;
    p = PASSWORD >> (k * CHAR_W);
    return p[CHAR_W-1:0];
  endfunction

  function automatic void model_reset();
    m_open = 1'b0; m_locked = 1'b0; m_fail = 0; m_q.delete();
  endfunction

  function automatic void model_press(input logic [CHAR_W-1:0] ch);
    bit ok;
    if (m_locked) return;
    if (m_open) begin m_open = 1'b0; return; end
    m_q.push_back(ch);
    if (m_q.size() == PW_LEN) begin
      ok = 1'b1;
      for (int k = 0; k < PW_LEN; k++) if (m_q[k] !== pw_char(k)) ok = 1'b0;
      if (ok) begin
        m_open = 1'b1; m_fail = 0;
      end else begin
        if (m_fail < MAX_TRIES) m_fail++;
        if (LOCK_EN && m_fail == MAX_TRIES) m_locked = 1'b1;
      end
      m_q.delete();
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; bus.enter = 1'b0; bus.char_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // One enter press held for 'hold' cycles, then enough idle time for the decision to land.
  task automatic press(input logic [CHAR_W-1:0] ch, input int hold);
    @(negedge clk);
    bus.char_in = ch; bus.enter = 1'b1;
    repeat (hold) @(negedge clk);
    bus.enter = 1'b0; bus.char_in = CHAR_W'($urandom);
    repeat (5) @(negedge clk);
    model_press(ch);
    $display("press ch=%h open=%0d locked=%0d fail=%0d idx=%0d", ch, bus.open, bus.locked_out,
             bus.fail_cnt, bus.entry_idx);
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.enter = 1'b0; bus.char_in = '0;
    @(posedge clk); #1;
    checks += 4;
    if (bus.open !== 1'b0) begin errors++; $display("FAIL reset_open got %b want 0", bus.open); end
    if (bus.locked_out !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", bus.locked_out); end
    if (bus.fail_cnt !== '0) begin errors++; $display("FAIL reset_fail got %0d want 0", bus.fail_cnt); end
    if (bus.entry_idx !== '0) begin errors++; $display("FAIL reset_idx got %0d want 0", bus.entry_idx); end
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    model_reset();
  endtask

  task automatic test_open_latency();
    do_reset();
    for (int k = 0; k < PW_LEN - 1; k++) press(pw_char(k), 1);
    @(negedge clk);
    bus.char_in = pw_char(PW_LEN - 1); bus.enter = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.open !== (e == 3)) begin
        errors++; $display("FAIL latency_edge%0d open got %b want %0d", e, bus.open, e == 3);
      end
    end
    @(negedge clk); bus.enter = 1'b0;
    repeat (3) @(negedge clk);
    model_press(pw_char(PW_LEN - 1));
    checks += 2;
    if (bus.fail_cnt !== FAIL_W'(m_fail)) begin errors++; $display("FAIL open_fail got %0d want %0d", bus.fail_cnt, m_fail); end
    if (bus.entry_idx !== '0) begin errors++; $display("FAIL open_idx got %0d want 0", bus.entry_idx); end
    press(pw_char(0), 2);
    checks += 2;
    if (bus.open !== m_open) begin errors++; $display("FAIL relock_open got %b want %b", bus.open, m_open); end
    if (bus.entry_idx !== IDX_W'(m_q.size())) begin errors++; $display("FAIL relock_idx got %0d want %0d", bus.entry_idx, m_q.size()); end
  endtask

  task automatic test_wrong_entry();
    do_reset();
    for (int k = 0; k < PW_LEN - 1; k++) press(pw_char(k), 1);
    press(pw_char(PW_LEN - 1) ^ 7'h01, 1);
    checks += 3;
    if (bus.open !== 1'b0) begin errors++; $display("FAIL wrong_open got %b want 0", bus.open); end
    if (bus.fail_cnt !== FAIL_W'(m_fail)) begin errors++; $display("FAIL wrong_fail got %0d want %0d", bus.fail_cnt, m_fail); end
    if (bus.entry_idx !== '0) begin errors++; $display("FAIL wrong_idx got %0d want 0", bus.entry_idx); end
    // Wrong first character: evaluation still waits for the full length.
    press(pw_char(0) ^ 7'h40, 2);
    for (int k = 1; k < PW_LEN - 1; k++) press(pw_char(k), 1);
    checks += 2;
    if (bus.entry_idx !== IDX_W'(m_q.size())) begin errors++; $display("FAIL early_idx got %0d want %0d", bus.entry_idx, m_q.size()); end
    if (bus.fail_cnt !== FAIL_W'(m_fail)) begin errors++; $display("FAIL early_fail got %0d want %0d", bus.fail_cnt, m_fail); end
    press(pw_char(PW_LEN - 1), 1);
    checks += 2;
    if (bus.fail_cnt !== FAIL_W'(m_fail)) begin errors++; $display("FAIL early_eval_fail got %0d want %0d", bus.fail_cnt, m_fail); end
    if (bus.open !== m_open) begin errors++; $display("FAIL early_eval_open got %b want %b", bus.open, m_open); end
  endtask

  task automatic test_held_enter();
    do_reset();
    press(pw_char(0), 50);
    checks++;
    if (bus.entry_idx !== IDX_W'(m_q.size())) begin errors++; $display("FAIL held_idx got %0d want %0d", bus.entry_idx, m_q.size()); end
    press(pw_char(1), 1);
    checks++;
    if (bus.entry_idx !== IDX_W'(m_q.size())) begin errors++; $display("FAIL held_idx2 got %0d want %0d", bus.entry_idx, m_q.size()); end
    do_reset();
    checks++;
    if (bus.entry_idx !== '0) begin errors++; $display("FAIL midreset_idx got %0d want 0", bus.entry_idx); end
    for (int k = 0; k < PW_LEN; k++) press(pw_char(k), 1);
    checks++;
    if (bus.open !== m_open) begin errors++; $display("FAIL held_open got %b want %b", bus.open, m_open); end
  endtask

`ifdef PW_SEQ_LOCK_LOCKOUT_EN
  task automatic test_lockout();
    int waited;
    do_reset();
    lo_cycles = 0;
    for (int a = 0; a < MAX_TRIES; a++) begin
      press(pw_char(0) ^ 7'h11, 1);
      for (int k = 1; k < PW_LEN; k++) press(pw_char(k), 1);
    end
    checks++;
    if (bus.locked_out !== m_locked) begin errors++; $display("FAIL lock_enter got %b want %b", bus.locked_out, m_locked); end
    for (int k = 0; k < PW_LEN; k++) press(pw_char(k), 1);
    checks += 3;
    if (bus.open !== m_open) begin errors++; $display("FAIL lock_ignore_open got %b want %b", bus.open, m_open); end
    if (bus.locked_out !== m_locked) begin errors++; $display("FAIL lock_hold got %b want %b", bus.locked_out, m_locked); end
    if (bus.entry_idx !== '0) begin errors++; $display("FAIL lock_idx got %0d want 0", bus.entry_idx); end
    waited = 0;
    while (bus.locked_out === 1'b1 && waited < 2 * LOCKOUT_CYC) begin
      @(negedge clk); waited++;
    end
    repeat (2) @(negedge clk);
    m_locked = 1'b0; m_fail = 0;
    checks += 3;
    if (bus.locked_out !== 1'b0) begin errors++; $display("FAIL lock_timeout locked still %b want 0", bus.locked_out); end
    if (lo_cycles != LOCKOUT_CYC) begin errors++; $display("FAIL lock_len got %0d want %0d", lo_cycles, LOCKOUT_CYC); end
    if (bus.fail_cnt !== FAIL_W'(m_fail)) begin errors++; $display("FAIL lock_fail_clr got %0d want 0", bus.fail_cnt); end
    for (int k = 0; k < PW_LEN; k++) press(pw_char(k), 1);
    checks++;
    if (bus.open !== m_open) begin errors++; $display("FAIL post_lock_open got %b want %b", bus.open, m_open); end
  endtask
`else
  task automatic test_saturate();
    do_reset();
    for (int a = 0; a < MAX_TRIES + 2; a++) begin
      press(pw_char(0) ^ 7'h22, 1);
      for (int k = 1; k < PW_LEN; k++) press(CHAR_W'($urandom), 1);
      checks += 2;
      if (bus.fail_cnt !== FAIL_W'(m_fail)) begin errors++; $display("FAIL sat_fail%0d got %0d want %0d", a, bus.fail_cnt, m_fail); end
      if (bus.locked_out !== 1'b0) begin errors++; $display("FAIL sat_locked got %b want 0", bus.locked_out); end
    end
    for (int k = 0; k < PW_LEN; k++) press(pw_char(k), 1);
    checks += 2;
    if (bus.open !== m_open) begin errors++; $display("FAIL sat_open got %b want %b", bus.open, m_open); end
    if (bus.fail_cnt !== FAIL_W'(m_fail)) begin errors++; $display("FAIL sat_clear got %0d want %0d", bus.fail_cnt, m_fail); end
  endtask
`endif

  task automatic test_random();
    logic [CHAR_W-1:0] ch;
    bit good;
    do_reset();
    for (int a = 0; a < 30; a++) begin
      good = ($urandom_range(0, 1) == 1);
      for (int k = 0; k < PW_LEN; k++) begin
        ch = good ? pw_char(k) : CHAR_W'($urandom);
        press(ch, $urandom_range(1, 4));
        checks += 4;
        if (bus.open !== m_open) begin errors++; $display("FAIL rnd_open got %b want %b", bus.open, m_open); end
        if (bus.locked_out !== m_locked) begin errors++; $display("FAIL rnd_locked got %b want %b", bus.locked_out, m_locked); end
        if (bus.fail_cnt !== FAIL_W'(m_fail)) begin errors++; $display("FAIL rnd_fail got %0d want %0d", bus.fail_cnt, m_fail); end
        if (bus.entry_idx !== IDX_W'(m_q.size())) begin errors++; $display("FAIL rnd_idx got %0d want %0d", bus.entry_idx, m_q.size()); end
        if (m_locked) begin
          repeat (LOCKOUT_CYC + 10) @(negedge clk);
          m_locked = 1'b0; m_fail = 0;
          checks += 2;
          if (bus.locked_out !== 1'b0) begin errors++; $display("FAIL rnd_unlock got %b want 0", bus.locked_out); end
          if (bus.fail_cnt !== '0) begin errors++; $display("FAIL rnd_unlock_fail got %0d want 0", bus.fail_cnt); end
        end
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.enter = 1'b0;
    bus.char_in = '0;
    model_reset();
    test_reset();
    test_open_latency();
    test_wrong_entry();
    test_held_enter();
`ifdef PW_SEQ_LOCK_LOCKOUT_EN
    test_lockout();
`else
    test_saturate();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
